// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The master drives the controls and observes count/tc/busy; the counter is the slave.
interface param_updown_counter_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             en;
   logic             up_dn;
   logic [1:0]       mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             busy;

   modport master (
      output en, up_dn, mode, load, load_val, start,
      input  count, tc, busy
   );

   modport slave (
      input  en, up_dn, mode, load, load_val, start,
      output count, tc, busy
   );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with wrap, saturate and one-shot modes.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN (adds PRESCALE parameter).
module param_updown_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
   parameter int unsigned RST_VAL  = 0
`ifdef COUNTER_PRESCALE_EN
   ,
   parameter int unsigned PRESCALE = 4
`endif
) (
   input logic                   clk,
   input logic                   rst_n,
   param_updown_counter_if.slave cnt_if
);

   localparam logic [WIDTH-1:0] MaxV        = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RstV        = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] Zero        = '0;
   localparam logic [WIDTH-1:0] One         = WIDTH'(1);
   localparam logic [1:0]       ModeSat     = 2'b01;
   localparam logic [1:0]       ModeOneShot = 2'b10;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;

   logic             is_oneshot;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] nxt;
   logic             wrapped;
   logic             at_limit;
   logic             step_qual;
   logic             tick;

   assign is_oneshot = (cnt_if.mode == ModeOneShot);
   assign limit      = cnt_if.up_dn ? MaxV : Zero;
   assign at_limit   = (count_q == limit);
   assign step_qual  = cnt_if.en && !cnt_if.load && (!is_oneshot || state_q == StRun);

`ifdef COUNTER_PRESCALE_EN
   localparam int unsigned PsW  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

   logic [PsW-1:0] ps_q, ps_d;

   assign tick = (ps_q == PsLast);

   always_comb begin
      ps_d = ps_q;
      if (cnt_if.load || cnt_if.start) begin
         ps_d = '0;
      end else if (step_qual) begin
         ps_d = tick ? '0 : ps_q + PsW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Candidate next value in the current direction, folded back into 0..MAX_VAL.
   always_comb begin
      wrapped = 1'b0;
      if (cnt_if.up_dn) begin
         if (count_q >= MaxV) begin
            nxt     = Zero;
            wrapped = 1'b1;
         end else begin
            nxt = count_q + One;
         end
      end else begin
         if (count_q == Zero) begin
            nxt     = MaxV;
            wrapped = 1'b1;
         end else begin
            nxt = count_q - One;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      state_d = state_q;

      if (cnt_if.load) begin
         count_d = (cnt_if.load_val > MaxV) ? MaxV : cnt_if.load_val;
      end else if (step_qual && tick) begin
         if (cnt_if.mode == ModeSat) begin
            if (!at_limit) begin
               count_d = nxt;
               tc_d    = (nxt == limit);
            end
         end else if (!is_oneshot) begin
            count_d = nxt;
            tc_d    = wrapped;
         end
      end

      if (!is_oneshot) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: if (cnt_if.start) state_d = StRun;
            StRun: begin
               // A load cycle leaves the FSM alone.
               if (!cnt_if.load) begin
                  if (at_limit) begin
                     state_d = StDone;
                     tc_d    = 1'b1;
                  end else if (step_qual && tick) begin
                     count_d = nxt;
                     if (nxt == limit) begin
                        state_d = StDone;
                        tc_d    = 1'b1;
                     end
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end

      busy_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= RstV;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
      end
   end

   assign cnt_if.count = count_q;
   assign cnt_if.tc    = tc_q;
   assign cnt_if.busy  = busy_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=4, MAX_VAL=9, RST_VAL=0, default build).
module tb_param_updown_counter;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   param_updown_counter_if #(.WIDTH(4)) cif ();

   param_updown_counter #(
      .WIDTH   (4),
      .MAX_VAL (9),
      .RST_VAL (0)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt_if (cif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int c, input int t, input int b);
      chk({tag, ".count"}, int'(cif.count), c);
      chk({tag, ".tc"},    int'(cif.tc),    t);
      chk({tag, ".busy"},  int'(cif.busy),  b);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      cif.en = 1'b0;
      cif.up_dn = 1'b1;
      cif.mode = 2'b00;
      cif.load = 1'b0;
      cif.load_val = '0;
      cif.start = 1'b0;

      #2;
      chk3("reset", 0, 0, 0);
      #10 rst_n = 1'b1;
      tick();
      chk3("post_reset", 0, 0, 0);

      // Wrap up
      cif.en = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk3($sformatf("wrap_up%0d", i), i % 10, (i % 10 == 0) ? 1 : 0, 0);
      end

      // Wrap down from 2
      cif.en = 1'b0;
      cif.load = 1'b1;
      cif.load_val = 4'd2;
      tick();
      chk3("load2", 2, 0, 0);
      cif.load = 1'b0;
      cif.up_dn = 1'b0;
      cif.en = 1'b1;
      tick(); chk3("wdn1", 1, 0, 0);
      tick(); chk3("wdn0", 0, 0, 0);
      tick(); chk3("wdn9", 9, 1, 0);
      tick(); chk3("wdn8", 8, 0, 0);

      // Load clamps and beats enable
      cif.up_dn = 1'b1;
      cif.load = 1'b1;
      cif.load_val = 4'd15;
      tick();
      chk3("load15_clamp", 9, 0, 0);
      cif.load_val = 4'd4;
      tick();
      chk3("load_beats_en", 4, 0, 0);

      // Saturate up from 7 then down
      cif.mode = 2'b01;
      cif.load_val = 4'd7;
      tick();
      chk3("sat_load7", 7, 0, 0);
      cif.load = 1'b0;
      tick(); chk3("sat_up8", 8, 0, 0);
      tick(); chk3("sat_up9", 9, 1, 0);
      tick(); chk3("sat_hold9a", 9, 0, 0);
      tick(); chk3("sat_hold9b", 9, 0, 0);
      cif.up_dn = 1'b0;
      for (int v = 8; v >= 0; v--) begin
         tick();
         chk3($sformatf("sat_dn%0d", v), v, (v == 0) ? 1 : 0, 0);
      end
      tick(); chk3("sat_hold0", 0, 0, 0);

      // One-shot: load 6, start, count up to 9
      cif.mode = 2'b10;
      cif.up_dn = 1'b1;
      cif.en = 1'b0;
      cif.load = 1'b1;
      cif.load_val = 4'd6;
      tick(); chk3("os_load6", 6, 0, 0);
      cif.load = 1'b0;
      cif.start = 1'b1;
      tick(); chk3("os_start", 6, 0, 1);
      cif.start = 1'b0;
      cif.en = 1'b1;
      tick(); chk3("os_7", 7, 0, 1);
      tick(); chk3("os_8", 8, 0, 1);
      tick(); chk3("os_9_done", 9, 1, 0);
      tick(); chk3("os_idle", 9, 0, 0);
      cif.en = 1'b0;
      tick(); chk3("os_idle_en0", 9, 0, 0);
      cif.en = 1'b1;
      tick(); chk3("os_idle_en1", 9, 0, 0);

      // RUN entered while already at the limit
      cif.en = 1'b0;
      cif.start = 1'b1;
      tick(); chk3("os_lim_start", 9, 0, 1);
      cif.start = 1'b0;
      tick(); chk3("os_lim_done", 9, 1, 0);
      tick(); chk3("os_lim_idle", 9, 0, 0);

      // Load and start together in IDLE
      cif.load = 1'b1;
      cif.load_val = 4'd3;
      cif.start = 1'b1;
      tick(); chk3("os_load_start", 3, 0, 1);
      cif.load = 1'b0;
      cif.start = 1'b0;
      cif.en = 1'b1;
      tick(); chk3("os_4", 4, 0, 1);
      tick(); chk3("os_5", 5, 0, 1);

      // Async reset mid-RUN, between edges
      #3 rst_n = 1'b0;
      #1 chk3("async_rst", 0, 0, 0);
      cif.mode = 2'b00;
      #2 rst_n = 1'b1;
      tick(); chk3("resume1", 1, 0, 0);
      tick(); chk3("resume2", 2, 0, 0);

      // Leaving one-shot forces IDLE, count kept
      cif.en = 1'b0;
      cif.mode = 2'b10;
      cif.start = 1'b1;
      tick(); chk3("os_run_again", 2, 0, 1);
      cif.start = 1'b0;
      cif.mode = 2'b00;
      tick(); chk3("mode_exit", 2, 0, 0);

      // Mode 11 behaves as wrap
      cif.mode = 2'b11;
      cif.load = 1'b1;
      cif.load_val = 4'd9;
      tick(); chk3("m11_load9", 9, 0, 0);
      cif.load = 1'b0;
      cif.en = 1'b1;
      tick(); chk3("m11_wrap0", 0, 1, 0);
      tick(); chk3("m11_1", 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
